// File: rtl/cache_axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel between icache and dcache.
// One AR burst in flight; R beats are steered to the latched owner.
module cache_axi_rd_arbiter #(
    parameter logic [3:0] ID_ICACHE   = 4'd0,
    parameter logic [3:0] ID_DCACHE   = 4'd1,
    parameter logic [2:0] ICACHE_SIZE = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_rd_req,
    input  logic [31:0] icache_rd_addr,
    input  logic [7:0]  icache_rd_len,
    output logic        icache_rd_grant,
    output logic        icache_ret_valid,
    output logic        icache_ret_last,
    output logic [31:0] icache_ret_data,
    input  logic        dcache_rd_req,
    input  logic [31:0] dcache_rd_addr,
    input  logic [7:0]  dcache_rd_len,
    input  logic [2:0]  dcache_rd_size,
    output logic        dcache_rd_grant,
    output logic        dcache_ret_valid,
    output logic        dcache_ret_last,
    output logic [31:0] dcache_ret_data,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        proto_err
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t      state;
    logic        owner_dcache;
    logic        rr_dcache_last;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [2:0]  size_q;
    logic [3:0]  id_q;
    logic [7:0]  cnt;
    logic        pick_i;
    logic        pick_d;
    logic        beat;
    logic        unused_rid;

    // Tie goes to whichever side was not granted last.
    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (state == IDLE && !rst) begin
            unique case ({icache_rd_req, dcache_rd_req})
                2'b10:   pick_i = 1'b1;
                2'b01:   pick_d = 1'b1;
                2'b11: begin
                    pick_i = rr_dcache_last;
                    pick_d = !rr_dcache_last;
                end
                default: ;
            endcase
        end
    end

    assign icache_rd_grant = pick_i;
    assign dcache_rd_grant = pick_d;

    assign beat = rvalid && rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            arvalid        <= 1'b0;
            rready         <= 1'b0;
            proto_err      <= 1'b0;
            rr_dcache_last <= 1'b0;
            owner_dcache   <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            size_q         <= '0;
            id_q           <= '0;
            cnt            <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_i || pick_d) begin
                        owner_dcache   <= pick_d;
                        rr_dcache_last <= pick_d;
                        addr_q  <= pick_d ? dcache_rd_addr : icache_rd_addr;
                        len_q   <= pick_d ? dcache_rd_len  : icache_rd_len;
                        size_q  <= pick_d ? dcache_rd_size : ICACHE_SIZE;
                        id_q    <= pick_d ? ID_DCACHE      : ID_ICACHE;
                        arvalid <= 1'b1;
                        state   <= AR;
                    end
                end
                AR: begin
                    if (arready) begin
                        cnt     <= '0;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (beat) begin
                        cnt <= cnt + 8'd1;
                        // rlast must coincide exactly with beat index == len
                        if (rlast != (cnt == len_q)) begin
                            proto_err <= 1'b1;
                        end
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_q;
    assign arburst = 2'b01;

    assign icache_ret_valid = beat && !owner_dcache;
    assign icache_ret_last  = rready && !owner_dcache && rlast;
    assign icache_ret_data  = rdata;
    assign dcache_ret_valid = beat && owner_dcache;
    assign dcache_ret_last  = rready && owner_dcache && rlast;
    assign dcache_ret_data  = rdata;

    assign unused_rid = ^rid;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Bench for cache_axi_rd_arbiter: AXI slave model, monitor and
// scenario tasks checked against a round-robin reference model.
module tb_cache_axi_rd_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        icache_rd_req;
    logic [31:0] icache_rd_addr;
    logic [7:0]  icache_rd_len;
    logic        icache_rd_grant;
    logic        icache_ret_valid;
    logic        icache_ret_last;
    logic [31:0] icache_ret_data;
    logic        dcache_rd_req;
    logic [31:0] dcache_rd_addr;
    logic [7:0]  dcache_rd_len;
    logic [2:0]  dcache_rd_size;
    logic        dcache_rd_grant;
    logic        dcache_ret_valid;
    logic        dcache_ret_last;
    logic [31:0] dcache_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        proto_err;

    cache_axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_rd_req(icache_rd_req), .icache_rd_addr(icache_rd_addr),
        .icache_rd_len(icache_rd_len), .icache_rd_grant(icache_rd_grant),
        .icache_ret_valid(icache_ret_valid), .icache_ret_last(icache_ret_last),
        .icache_ret_data(icache_ret_data),
        .dcache_rd_req(dcache_rd_req), .dcache_rd_addr(dcache_rd_addr),
        .dcache_rd_len(dcache_rd_len), .dcache_rd_size(dcache_rd_size),
        .dcache_rd_grant(dcache_rd_grant),
        .dcache_ret_valid(dcache_ret_valid), .dcache_ret_last(dcache_ret_last),
        .dcache_ret_data(dcache_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
        .rready(rready), .proto_err(proto_err)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int gi_q[$];
    int gd_q[$];
    int av_q[$];
    int rr_q[$];
    int hold_q[$];
    int dlast_q[$];
    ar_t ar_q[$];
    logic [32:0] iq[$];
    logic [32:0] dq[$];
    logic [32:0] sent_i[$];
    logic [32:0] sent_d[$];
    int ar_unstable = 0;
    int both_v = 0;
    int ar_wait = 0;
    int early_last = -1;
    bit slave_busy = 1'b0;

    // AXI slave: optional AR stall, random gaps between beats
    initial begin : slave
        int sid;
        int last_idx;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rdata   = '0;
        rid     = '0;
        @(posedge clk); #1;
        forever begin
            if (arvalid === 1'b1 && rst === 1'b0) begin
                slave_busy = 1'b1;
                sid = int'(arid);
                last_idx = (early_last >= 0) ? early_last : int'(arlen);
                repeat (ar_wait) begin @(posedge clk); #1; end
                arready = 1'b1;
                @(posedge clk); #1;
                arready = 1'b0;
                for (int b = 0; b <= last_idx; b++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    rvalid = 1'b1;
                    rdata  = $urandom;
                    rlast  = (b == last_idx);
                    rid    = sid[3:0];
                    if (sid == 0) sent_i.push_back({rlast, rdata});
                    else          sent_d.push_back({rlast, rdata});
                    @(posedge clk); #1;
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
                slave_busy = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
    end

    initial begin : monitor
        logic pav;
        logic prr;
        int   hold;
        ar_t  cur;
        ar_t  prev;
        pav = 1'b0; prr = 1'b0; hold = 0; prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {arid, araddr, arlen, arsize, arburst};
            if (icache_rd_grant === 1'b1) gi_q.push_back(cyc);
            if (dcache_rd_grant === 1'b1) gd_q.push_back(cyc);
            if (arvalid === 1'b1 && !pav) av_q.push_back(cyc);
            if (arvalid === 1'b1) begin
                if (pav && cur !== prev) ar_unstable++;
                hold++;
                if (arready) begin
                    ar_q.push_back(cur);
                    hold_q.push_back(hold);
                    hold = 0;
                end
            end
            if (rready === 1'b1 && !prr) rr_q.push_back(cyc);
            if (icache_ret_valid === 1'b1)
                iq.push_back({icache_ret_last, icache_ret_data});
            if (dcache_ret_valid === 1'b1) begin
                dq.push_back({dcache_ret_last, dcache_ret_data});
                if (dcache_ret_last) dlast_q.push_back(cyc);
            end
            if (icache_ret_valid === 1'b1 && dcache_ret_valid === 1'b1) both_v++;
            pav = (arvalid === 1'b1);
            prr = (rready === 1'b1);
            prev = cur;
        end
    end

    task automatic step();
        bit gi;
        bit gd;
        @(negedge clk);
        gi = (icache_rd_grant === 1'b1);
        gd = (dcache_rd_grant === 1'b1);
        @(posedge clk); #1;
        if (gi) icache_rd_req = 1'b0;
        if (gd) dcache_rd_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            step();
            if (!slave_busy && !icache_rd_req && !dcache_rd_req &&
                arvalid !== 1'b1 && rready !== 1'b1) break;
        end
        if (k == 400) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: busy after %0d cycles, required idle", name, k);
            icache_rd_req = 1'b0;
            dcache_rd_req = 1'b0;
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (arvalid !== 1'b0) begin n_err++;
            $display("FAIL reset_arvalid: got %b want 0", arvalid); end
        n_cmp++; if (rready !== 1'b0) begin n_err++;
            $display("FAIL reset_rready: got %b want 0", rready); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++;
            $display("FAIL reset_proto_err: got %b want 0", proto_err); end
        n_cmp++; if ({icache_rd_grant, dcache_rd_grant} !== 2'b00) begin n_err++;
            $display("FAIL reset_grants: got %b%b want 00", icache_rd_grant, dcache_rd_grant); end
        n_cmp++; if ({icache_ret_valid, dcache_ret_valid} !== 2'b00) begin n_err++;
            $display("FAIL reset_ret_valid: got %b%b want 00", icache_ret_valid, dcache_ret_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_icache_burst();
        int  g0 = gi_q.size();
        int  v0 = av_q.size();
        int  r0 = rr_q.size();
        int  a0 = ar_q.size();
        int  i0 = iq.size();
        int  s0 = sent_i.size();
        int  d0 = dq.size();
        int  c0 = cyc + 1;
        int  got;
        int  bad = 0;
        ar_t exp_ar = {4'd0, 32'h1C00_0000, 8'd7, 3'b010, 2'b01};
        ar_wait = 0;
        icache_rd_addr = 32'h1C00_0000;
        icache_rd_len  = 8'd7;
        icache_rd_req  = 1'b1;
        wait_idle("icache_burst");
        got = (gi_q.size() > g0) ? gi_q[g0] - c0 : -1;
        n_cmp++; if (got != 0) begin n_err++;
            $display("FAIL icache_grant_cycle: got %0d want 0", got); end
        got = (av_q.size() > v0) ? av_q[v0] - c0 : -1;
        n_cmp++; if (got != 1) begin n_err++;
            $display("FAIL icache_arvalid_cycle: got %0d want 1", got); end
        got = (rr_q.size() > r0) ? rr_q[r0] - c0 : -1;
        n_cmp++; if (got != 2) begin n_err++;
            $display("FAIL icache_rready_cycle: got %0d want 2", got); end
        n_cmp++; if (ar_q.size() <= a0 || ar_q[a0] !== exp_ar) begin n_err++;
            $display("FAIL icache_ar_fields: got %h want %h",
                     (ar_q.size() > a0) ? ar_q[a0] : '0, exp_ar); end
        n_cmp++; if (iq.size() - i0 != 8) begin n_err++;
            $display("FAIL icache_beats: got %0d want 8", iq.size() - i0); end
        for (int j = 0; j < 8 && i0 + j < iq.size() && s0 + j < sent_i.size(); j++)
            if (iq[i0 + j] !== sent_i[s0 + j] || iq[i0 + j][32] !== (j == 7)) bad++;
        n_cmp++; if (bad != 0) begin n_err++;
            $display("FAIL icache_data_last: got %0d bad beats want 0", bad); end
        n_cmp++; if (dq.size() != d0) begin n_err++;
            $display("FAIL icache_no_dcache: got %0d dcache beats want 0", dq.size() - d0); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++;
            $display("FAIL icache_proto_err: got %b want 0", proto_err); end
    endtask

    task automatic test_simultaneous();
        int gi0;
        int gd0;
        int dl0;
        int gi_c;
        int gd_c;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ar_wait = 0;
        for (int rnd = 0; rnd < 2; rnd++) begin
            gi0 = gi_q.size();
            gd0 = gd_q.size();
            dl0 = dlast_q.size();
            icache_rd_addr = 32'h1C00_1000 + 32'(rnd * 64);
            icache_rd_len  = 8'd7;
            dcache_rd_addr = 32'h0000_2000 + 32'(rnd * 64);
            dcache_rd_len  = 8'd7;
            dcache_rd_size = 3'b010;
            icache_rd_req  = 1'b1;
            dcache_rd_req  = 1'b1;
            wait_idle("simultaneous");
            gi_c = (gi_q.size() > gi0) ? gi_q[gi0] : -1;
            gd_c = (gd_q.size() > gd0) ? gd_q[gd0] : -1;
            n_cmp++; if (gd_c < 0 || gi_c < 0 || gd_c >= gi_c) begin n_err++;
                $display("FAIL rr_round%0d_order: dcache grant %0d icache grant %0d want dcache first",
                         rnd, gd_c, gi_c); end
            if (rnd == 0) begin
                n_cmp++;
                if (dlast_q.size() <= dl0 || gi_c != dlast_q[dl0] + 1) begin n_err++;
                    $display("FAIL rr_icache_after_dlast: got grant %0d want %0d",
                             gi_c, (dlast_q.size() > dl0) ? dlast_q[dl0] + 1 : -1); end
            end
        end
    endtask

    task automatic test_ar_stall();
        int  h0 = hold_q.size();
        int  a0 = ar_q.size();
        int  v0 = av_q.size();
        int  r0 = rr_q.size();
        int  u0 = ar_unstable;
        int  got;
        logic [31:0] ad = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
        ar_t exp_ar = {4'd1, ad, 8'd3, 3'b010, 2'b01};
        ar_wait = 3;
        dcache_rd_addr = ad;
        dcache_rd_len  = 8'd3;
        dcache_rd_size = 3'b010;
        dcache_rd_req  = 1'b1;
        wait_idle("ar_stall");
        ar_wait = 0;
        got = (hold_q.size() > h0) ? hold_q[h0] : -1;
        n_cmp++; if (got != 4) begin n_err++;
            $display("FAIL stall_arvalid_cycles: got %0d want 4", got); end
        n_cmp++; if (ar_unstable != u0) begin n_err++;
            $display("FAIL stall_fields_stable: got %0d changes want 0", ar_unstable - u0); end
        n_cmp++; if (ar_q.size() <= a0 || ar_q[a0] !== exp_ar) begin n_err++;
            $display("FAIL stall_ar_fields: got %h want %h",
                     (ar_q.size() > a0) ? ar_q[a0] : '0, exp_ar); end
        got = (rr_q.size() > r0 && av_q.size() > v0) ? rr_q[r0] - av_q[v0] : -1;
        n_cmp++; if (got != 4) begin n_err++;
            $display("FAIL stall_r_after_hs: got %0d want 4", got); end
    endtask

    task automatic test_uncached();
        int  a0 = ar_q.size();
        int  d0 = dq.size();
        int  s0 = sent_d.size();
        int  i0 = iq.size();
        ar_t exp_ar = {4'd1, 32'hBFAF_8003, 8'd0, 3'b000, 2'b01};
        ar_wait = $urandom_range(0, 2);
        dcache_rd_addr = 32'hBFAF_8003;
        dcache_rd_len  = 8'd0;
        dcache_rd_size = 3'b000;
        dcache_rd_req  = 1'b1;
        wait_idle("uncached");
        ar_wait = 0;
        n_cmp++; if (ar_q.size() <= a0 || ar_q[a0] !== exp_ar) begin n_err++;
            $display("FAIL uncached_ar_fields: got %h want %h",
                     (ar_q.size() > a0) ? ar_q[a0] : '0, exp_ar); end
        n_cmp++; if (dq.size() - d0 != 1) begin n_err++;
            $display("FAIL uncached_beats: got %0d want 1", dq.size() - d0); end
        n_cmp++;
        if (dq.size() <= d0 || sent_d.size() <= s0 ||
            dq[d0] !== sent_d[s0] || dq[d0][32] !== 1'b1) begin n_err++;
            $display("FAIL uncached_data_last: got %h want %h",
                     (dq.size() > d0) ? dq[d0] : '0,
                     (sent_d.size() > s0) ? sent_d[s0] : '0); end
        n_cmp++; if (iq.size() != i0) begin n_err++;
            $display("FAIL uncached_icache_quiet: got %0d icache beats want 0", iq.size() - i0); end
    endtask

    task automatic test_early_last();
        int i0 = iq.size();
        int g0 = gd_q.size();
        int d0 = dq.size();
        early_last = 3;
        icache_rd_addr = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
        icache_rd_len  = 8'd7;
        icache_rd_req  = 1'b1;
        wait_idle("early_last");
        early_last = -1;
        n_cmp++; if (iq.size() - i0 != 4) begin n_err++;
            $display("FAIL early_beats: got %0d want 4", iq.size() - i0); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++;
            $display("FAIL early_proto_err: got %b want 1", proto_err); end
        repeat (3) step();
        dcache_rd_addr = 32'h0000_4000;
        dcache_rd_len  = 8'd1;
        dcache_rd_size = 3'b010;
        dcache_rd_req  = 1'b1;
        wait_idle("early_next");
        n_cmp++; if (gd_q.size() != g0 + 1 || dq.size() - d0 != 2) begin n_err++;
            $display("FAIL early_next_grant: got %0d grants %0d beats want 1 grant 2 beats",
                     gd_q.size() - g0, dq.size() - d0); end
        n_cmp++; if (proto_err !== 1'b1) begin n_err++;
            $display("FAIL early_proto_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_mid_reset();
        int i0 = iq.size();
        int n_after;
        int k;
        ar_wait = 0;
        icache_rd_addr = 32'h1C00_8000;
        icache_rd_len  = 8'd7;
        icache_rd_req  = 1'b1;
        for (k = 0; k < 200 && iq.size() - i0 < 3; k++) step();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_after = iq.size();
        @(negedge clk);
        n_cmp++; if ({rready, arvalid} !== 2'b00) begin n_err++;
            $display("FAIL midrst_idle: got rready %b arvalid %b want 0 0", rready, arvalid); end
        n_cmp++; if (proto_err !== 1'b0) begin n_err++;
            $display("FAIL midrst_proto_err: got %b want 0", proto_err); end
        for (k = 0; k < 100 && slave_busy; k++) step();
        step();
        n_cmp++; if (iq.size() != n_after || n_after - i0 < 3) begin n_err++;
            $display("FAIL midrst_no_steer: got %0d beats after reset want 0 (before %0d)",
                     iq.size() - n_after, n_after - i0); end
    endtask

    task automatic test_random();
        bit  dcache_last = 1'b0;
        ar_t exp_ar[$];
        for (int r = 0; r < 16; r++) begin
            int  mode = $urandom_range(1, 3);
            bit  wi = mode[0];
            bit  wd = mode[1];
            int  li = $urandom_range(0, 7);
            int  ld = $urandom_range(0, 7);
            logic [2:0]  sd = 3'($urandom_range(0, 2));
            logic [31:0] ai = {$urandom_range(0, 32'h0FFF_FFFF), 4'h0};
            logic [31:0] ad = $urandom;
            int  a0 = ar_q.size();
            int  h0 = hold_q.size();
            int  i0 = iq.size();
            int  d0 = dq.size();
            int  si0 = sent_i.size();
            int  sd0 = sent_d.size();
            int  bad = 0;
            ar_t ri = {4'd0, ai, 8'(li), 3'b010, 2'b01};
            ar_t rd = {4'd1, ad, 8'(ld), sd, 2'b01};
            exp_ar.delete();
            if (wi && wd) begin
                if (dcache_last) begin exp_ar.push_back(ri); exp_ar.push_back(rd); end
                else begin exp_ar.push_back(rd); exp_ar.push_back(ri); end
            end else if (wi) exp_ar.push_back(ri);
            else exp_ar.push_back(rd);
            dcache_last = (exp_ar[exp_ar.size() - 1].id == 4'd1);
            ar_wait = $urandom_range(0, 3);
            icache_rd_addr = ai; icache_rd_len = 8'(li);
            dcache_rd_addr = ad; dcache_rd_len = 8'(ld); dcache_rd_size = sd;
            icache_rd_req = wi;
            dcache_rd_req = wd;
            wait_idle("random");
            n_cmp++; if (ar_q.size() - a0 != exp_ar.size()) begin n_err++;
                $display("FAIL rand%0d_ar_count: got %0d want %0d", r, ar_q.size() - a0, exp_ar.size()); end
            for (int j = 0; j < exp_ar.size() && a0 + j < ar_q.size(); j++) begin
                n_cmp++; if (ar_q[a0 + j] !== exp_ar[j]) begin n_err++;
                    $display("FAIL rand%0d_ar%0d: got %h want %h", r, j, ar_q[a0 + j], exp_ar[j]); end
                n_cmp++; if (hold_q.size() <= h0 + j || hold_q[h0 + j] != ar_wait + 1) begin n_err++;
                    $display("FAIL rand%0d_hold%0d: got %0d want %0d", r, j,
                             (hold_q.size() > h0 + j) ? hold_q[h0 + j] : -1, ar_wait + 1); end
            end
            n_cmp++;
            if (iq.size() - i0 != (wi ? li + 1 : 0) || dq.size() - d0 != (wd ? ld + 1 : 0)) begin
                n_err++;
                $display("FAIL rand%0d_beats: got i%0d d%0d want i%0d d%0d", r,
                         iq.size() - i0, dq.size() - d0, wi ? li + 1 : 0, wd ? ld + 1 : 0); end
            for (int j = 0; i0 + j < iq.size() && si0 + j < sent_i.size(); j++)
                if (iq[i0 + j] !== sent_i[si0 + j] || iq[i0 + j][32] !== (j == li)) bad++;
            for (int j = 0; d0 + j < dq.size() && sd0 + j < sent_d.size(); j++)
                if (dq[d0 + j] !== sent_d[sd0 + j] || dq[d0 + j][32] !== (j == ld)) bad++;
            n_cmp++; if (bad != 0) begin n_err++;
                $display("FAIL rand%0d_data: got %0d bad beats want 0", r, bad); end
        end
        ar_wait = 0;
        n_cmp++; if (proto_err !== 1'b0) begin n_err++;
            $display("FAIL rand_proto_err: got %b want 0", proto_err); end
        n_cmp++; if (both_v != 0) begin n_err++;
            $display("FAIL both_ret_valid: got %0d cycles want 0", both_v); end
    endtask

    initial begin
        rst = 1'b1;
        icache_rd_req = 1'b0;
        icache_rd_addr = '0;
        icache_rd_len = '0;
        dcache_rd_req = 1'b0;
        dcache_rd_addr = '0;
        dcache_rd_len = '0;
        dcache_rd_size = '0;
        test_reset();
        test_icache_burst();
        test_simultaneous();
        test_ar_stall();
        test_uncached();
        test_early_last();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
